// File: rtl/imem_load_ctrl.sv
// Loads the instruction memory word by word from an external source while holding the core,
// then pulses a core restart. A load that stalls too long parks in an error state.
module imem_load_ctrl #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned TMO_W   = 8,
    parameter int unsigned TMO_MAX = 255
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              load_start,
    input  logic [ADDR_W:0]   load_len,
    input  logic              exIns_valid,
    input  logic [31:0]       exIns_in,
    output logic              exIns_ren,
    output logic [31:0]       exIns_addr,
    input  logic              core_fetch_en,
    input  logic [31:0]       core_pc,
    output logic [31:0]       core_inst,
    output logic              core_hold,
    output logic              core_restart,
    output logic              imem_en,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic [31:0]       imem_rdata,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err
);

    typedef enum logic [2:0] {StIdle, StReq, StWr, StDone, StErr} stateE;

    stateE             stateQ, stateD;
    logic [ADDR_W:0]   cntQ, cntD;
    logic [ADDR_W:0]   lenQ, lenD;
    logic [TMO_W-1:0]  tmoQ, tmoD;
    logic [31:0]       dataQ, dataD;
    logic              doneQ, doneD;
    logic              errQ, errD;
    logic              renQ, restartQ, busyQ;
    logic [31:0]       addrQ;

    logic unusedPc;
    assign unusedPc = ^{core_pc[31:ADDR_W+2], core_pc[1:0]};

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        lenD   = lenQ;
        tmoD   = tmoQ;
        dataD  = dataQ;
        doneD  = doneQ;
        errD   = errQ;
        unique case (stateQ)
            StIdle, StErr: begin
                if (load_start) begin
                    lenD   = load_len;
                    cntD   = '0;
                    tmoD   = '0;
                    doneD  = 1'b0;
                    errD   = 1'b0;
                    stateD = (load_len == '0) ? StDone : StReq;
                end
            end
            StReq: begin
                if (exIns_valid) begin
                    dataD  = exIns_in;
                    stateD = StWr;
                end else if (tmoQ == TMO_W'(TMO_MAX - 1)) begin
                    stateD = StErr;
                end else begin
                    tmoD = tmoQ + 1'b1;
                end
            end
            StWr: begin
                cntD   = cntQ + 1'b1;
                tmoD   = '0;
                stateD = (cntD == lenQ) ? StDone : StReq;
            end
            StDone:  stateD = StIdle;
            default: stateD = StIdle;
        endcase
        // Flags become visible in the same cycle the terminal state is entered.
        if (stateD == StDone) doneD = 1'b1;
        if (stateD == StErr)  errD  = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            stateQ   <= StIdle;
            cntQ     <= '0;
            lenQ     <= '0;
            tmoQ     <= '0;
            dataQ    <= '0;
            doneQ    <= 1'b0;
            errQ     <= 1'b0;
            renQ     <= 1'b0;
            restartQ <= 1'b0;
            busyQ    <= 1'b0;
            addrQ    <= '0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            lenQ     <= lenD;
            tmoQ     <= tmoD;
            dataQ    <= dataD;
            doneQ    <= doneD;
            errQ     <= errD;
            // Registered outputs are decoded from the next state so they align with it.
            renQ     <= (stateD == StReq);
            restartQ <= (stateD == StDone);
            busyQ    <= (stateD == StReq) || (stateD == StWr);
            if (stateD == StReq) addrQ <= 32'(cntD) << 2;
        end
    end

    assign exIns_ren    = renQ;
    assign exIns_addr   = addrQ;
    assign core_restart = restartQ;
    assign load_busy    = busyQ;
    assign load_done    = doneQ;
    assign load_err     = errQ;
    assign core_inst    = imem_rdata;
    assign imem_wdata   = dataQ;

    always_comb begin
        imem_en   = 1'b0;
        imem_we   = 1'b0;
        imem_addr = cntQ[ADDR_W-1:0];
        core_hold = 1'b1;
        if (stateQ == StIdle) begin
            imem_en   = core_fetch_en;
            imem_addr = core_pc[ADDR_W+1:2];
            core_hold = 1'b0;
        end else if (stateQ == StWr) begin
            imem_en = 1'b1;
            imem_we = 1'b1;
        end
    end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed bench for imem_load_ctrl: IDLE pass-through vectors plus load, timeout,
// ignored-start and mid-load reset sequences.
module tb_imem_load_ctrl;

    localparam int unsigned AW = 4;

    logic          clk = 1'b0;
    logic          nrst;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          exIns_valid;
    logic [31:0]   exIns_in;
    logic          exIns_ren;
    logic [31:0]   exIns_addr;
    logic          core_fetch_en;
    logic [31:0]   core_pc;
    logic [31:0]   core_inst;
    logic          core_hold;
    logic          core_restart;
    logic          imem_en;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [31:0]   imem_rdata;
    logic          load_busy;
    logic          load_done;
    logic          load_err;

    imem_load_ctrl #(.ADDR_W(AW), .TMO_W(8), .TMO_MAX(4)) dut (
        .clk(clk), .nrst(nrst), .load_start(load_start), .load_len(load_len),
        .exIns_valid(exIns_valid), .exIns_in(exIns_in), .exIns_ren(exIns_ren),
        .exIns_addr(exIns_addr), .core_fetch_en(core_fetch_en), .core_pc(core_pc),
        .core_inst(core_inst), .core_hold(core_hold), .core_restart(core_restart),
        .imem_en(imem_en), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_rdata(imem_rdata), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // External source returns a word derived from the requested byte address.
    assign exIns_in = {16'hC0DE, exIns_addr[15:0]};

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
        int          cyc;
    } wrT;

    wrT wrLog[$];
    int cyc = 0;
    int restartCnt = 0;
    int lastRestart = -1;
    int renCnt = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (imem_en && imem_we) wrLog.push_back('{int'(imem_addr), imem_wdata, cyc});
        if (core_restart) begin
            restartCnt  <= restartCnt + 1;
            lastRestart <= cyc;
        end
        if (exIns_ren) renCnt <= renCnt + 1;
    end

    int total = 0;
    int bad = 0;
    int startCyc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Returns on the falling edge just after the edge that sampled load_start.
    task automatic pulseStart(input logic [AW:0] len);
        @(negedge clk);
        load_start = 1'b1;
        load_len   = len;
        startCyc   = cyc;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    typedef struct {
        logic          fe;
        logic [31:0]   pc;
        logic [31:0]   rd;
        logic          expEn;
        logic [AW-1:0] expAddr;
    } vecT;

    vecT vecs[4];
    int  wBase, rBase, nBase;

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0010, 32'h1234_5678, 1'b1, 4'h4};
        vecs[1] = '{1'b0, 32'h0000_003C, 32'hDEAD_BEEF, 1'b0, 4'hF};
        vecs[2] = '{1'b1, 32'h0000_0040, 32'h0000_0001, 1'b1, 4'h0};
        vecs[3] = '{1'b1, 32'h0000_002B, 32'hA5A5_5A5A, 1'b1, 4'hA};

        nrst = 1'b0; load_start = 1'b0; load_len = '0; exIns_valid = 1'b1;
        core_fetch_en = 1'b0; core_pc = '0; imem_rdata = '0;
        waitCycles(3);
        nrst = 1'b1;
        #1;
        check("rst_ren", 32'(exIns_ren), 32'd0);
        check("rst_addr", exIns_addr, 32'd0);
        check("rst_restart", 32'(core_restart), 32'd0);
        check("rst_busy", 32'(load_busy), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_hold", 32'(core_hold), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            core_fetch_en = vecs[i].fe;
            core_pc       = vecs[i].pc;
            imem_rdata    = vecs[i].rd;
            #1;
            check($sformatf("vec%0d_en", i), 32'(imem_en), 32'(vecs[i].expEn));
            check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].expAddr));
            check($sformatf("vec%0d_we", i), 32'(imem_we), 32'd0);
            check($sformatf("vec%0d_hold", i), 32'(core_hold), 32'd0);
            check($sformatf("vec%0d_inst", i), core_inst, vecs[i].rd);
        end

        // Three-word load with the source always ready; core keeps fetching.
        core_fetch_en = 1'b1;
        wBase = wrLog.size(); rBase = restartCnt;
        pulseStart(3);
        check("l3_busy", 32'(load_busy), 32'd1);
        check("l3_ren", 32'(exIns_ren), 32'd1);
        check("l3_addr0", exIns_addr, 32'd0);
        check("l3_hold", 32'(core_hold), 32'd1);
        check("l3_fetch_blocked", 32'(imem_en), 32'd0);
        waitCycles(2);
        check("l3_ren1", 32'(exIns_ren), 32'd1);
        check("l3_addr1", exIns_addr, 32'd4);
        waitCycles(6);
        check("l3_nwr", 32'(wrLog.size() - wBase), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (wBase + k < wrLog.size()) begin
                check($sformatf("l3_wa%0d", k), wrLog[wBase+k].addr, 32'(k));
                check($sformatf("l3_wd%0d", k), wrLog[wBase+k].data, {16'hC0DE, 16'(4*k)});
                check($sformatf("l3_wc%0d", k), 32'(wrLog[wBase+k].cyc - startCyc),
                      32'(2*(k+1)));
            end
        end
        check("l3_restart_n", 32'(restartCnt - rBase), 32'd1);
        check("l3_restart_cyc", 32'(lastRestart - startCyc), 32'd7);
        check("l3_done", 32'(load_done), 32'd1);
        check("l3_idle_hold", 32'(core_hold), 32'd0);
        check("l3_idle_busy", 32'(load_busy), 32'd0);

        // Zero-length load goes straight to DONE.
        core_fetch_en = 1'b0;
        wBase = wrLog.size(); rBase = restartCnt; nBase = renCnt;
        pulseStart(0);
        check("l0_restart", 32'(core_restart), 32'd1);
        check("l0_hold", 32'(core_hold), 32'd1);
        check("l0_busy", 32'(load_busy), 32'd0);
        check("l0_done", 32'(load_done), 32'd1);
        waitCycles(3);
        check("l0_nwr", 32'(wrLog.size() - wBase), 32'd0);
        check("l0_nren", 32'(renCnt - nBase), 32'd0);
        check("l0_restart_n", 32'(restartCnt - rBase), 32'd1);
        check("l0_hold_after", 32'(core_hold), 32'd0);

        // Source never answers: four REQ cycles, then ERR until the next start.
        exIns_valid = 1'b0;
        wBase = wrLog.size(); rBase = restartCnt; nBase = renCnt;
        pulseStart(2);
        check("to_done_clr", 32'(load_done), 32'd0);
        waitCycles(3);
        check("to_still_req", 32'(load_err), 32'd0);
        waitCycles(1);
        check("to_err", 32'(load_err), 32'd1);
        check("to_ren_off", 32'(exIns_ren), 32'd0);
        check("to_busy", 32'(load_busy), 32'd0);
        waitCycles(10);
        check("to_hold", 32'(core_hold), 32'd1);
        check("to_err_sticky", 32'(load_err), 32'd1);
        check("to_nren", 32'(renCnt - nBase), 32'd4);
        check("to_nwr", 32'(wrLog.size() - wBase), 32'd0);
        check("to_restart_n", 32'(restartCnt - rBase), 32'd0);
        exIns_valid = 1'b1;
        pulseStart(2);
        check("to_err_clr", 32'(load_err), 32'd0);
        waitCycles(6);
        check("to_rec_nwr", 32'(wrLog.size() - wBase), 32'd2);
        check("to_rec_done", 32'(load_done), 32'd1);
        check("to_rec_hold", 32'(core_hold), 32'd0);

        // A second start during a load must not restart or shorten it.
        wBase = wrLog.size(); rBase = restartCnt;
        pulseStart(4);
        waitCycles(2);
        load_start = 1'b1; load_len = 5'd1;
        @(negedge clk);
        load_start = 1'b0;
        waitCycles(10);
        check("ign_nwr", 32'(wrLog.size() - wBase), 32'd4);
        if (wrLog.size() >= wBase + 4)
            check("ign_last_addr", wrLog[wBase+3].addr, 32'd3);
        check("ign_restart_n", 32'(restartCnt - rBase), 32'd1);

        // Reset during the second WR of a four-word load.
        wBase = wrLog.size(); rBase = restartCnt;
        pulseStart(4);
        waitCycles(3);
        check("rm_in_wr1_we", 32'(imem_we), 32'd1);
        check("rm_in_wr1_addr", 32'(imem_addr), 32'd1);
        nrst = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        check("rm_hold", 32'(core_hold), 32'd0);
        check("rm_busy", 32'(load_busy), 32'd0);
        waitCycles(10);
        check("rm_nwr", 32'(wrLog.size() - wBase), 32'd2);
        for (int k = wBase; k < wrLog.size(); k++)
            if (wrLog[k].addr >= 2) check("rm_high_write", wrLog[k].addr, 32'd0);
        check("rm_done", 32'(load_done), 32'd0);
        check("rm_restart_n", 32'(restartCnt - rBase), 32'd0);

        // Full-depth load: every word written, no wrap before completion.
        wBase = wrLog.size(); rBase = restartCnt;
        pulseStart(5'd16);
        waitCycles(40);
        check("full_nwr", 32'(wrLog.size() - wBase), 32'd16);
        if (wrLog.size() >= wBase + 16) begin
            check("full_last_addr", wrLog[wBase+15].addr, 32'd15);
            check("full_last_data", wrLog[wBase+15].data, {16'hC0DE, 16'd60});
        end
        check("full_done", 32'(load_done), 32'd1);
        check("full_restart_n", 32'(restartCnt - rBase), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
